// File: rtl/spi_rx_frame_parser.sv
// SPI receive-frame assembler: collects CMD/ADDR/DATA/CRC bytes while slave-select is low,
// then on the select rise publishes a good frame or classifies and counts the error.
module spi_rx_frame_parser #(
  parameter int          DATA_BYTES = 4,
  parameter logic [7:0]  CRC_POLY   = 8'h07,
  parameter logic [7:0]  CRC_INIT   = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    spi_ss,
  input  logic                    spi_rx_valid,
  input  logic [7:0]              spi_rx_byte,
  output logic [7:0]              frame_cmd,
  output logic [7:0]              frame_addr,
  output logic [8*DATA_BYTES-1:0] frame_data,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic [1:0]              err_code,
  output logic                    busy,
  output logic [7:0]              err_count
);

  localparam int FRAME_BYTES = DATA_BYTES + 3;
  localparam int CW          = $clog2(FRAME_BYTES + 2);

  localparam logic [1:0] CODE_NONE  = 2'd0;
  localparam logic [1:0] CODE_SHORT = 2'd1;
  localparam logic [1:0] CODE_LONG  = 2'd2;
  localparam logic [1:0] CODE_CRC   = 2'd3;

  typedef enum logic {IDLE, RECV} state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_base, cnt_d;
  logic [7:0]                  crc_q, crc_base, crc_d;
  logic [FRAME_BYTES-1:0][7:0] stage_q;
  logic                        accept;
  logic                        eval;
  logic                        eval_good, eval_bad;
  logic [1:0]                  eval_code;

  // Eight MSB-first shift steps, unrolled into one combinational stage.
  function automatic logic [7:0] crc8(input logic [7:0] d);
    logic [7:0] c;
    c = d;
    for (int i = 0; i < 8; i++)
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    eval    = 1'b0;
    case (state_q)
      IDLE: if (!spi_ss) state_d = RECV;
      RECV: if (spi_ss) begin
        state_d = IDLE;
        eval    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == RECV);
  assign accept = !spi_ss && spi_rx_valid;

  // A byte on the first low edge must see a fresh counter/CRC, so IDLE bypasses the registers.
  always_comb begin
    cnt_base = (state_q == IDLE) ? '0 : cnt_q;
    crc_base = (state_q == IDLE) ? CRC_INIT : crc_q;
    cnt_d    = cnt_base;
    crc_d    = crc_base;
    if (accept && cnt_base < CW'(FRAME_BYTES + 1))
      cnt_d = cnt_base + 1'b1;
    if (accept && cnt_base < CW'(FRAME_BYTES - 1))
      crc_d = crc8(crc_base ^ spi_rx_byte);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      crc_q <= CRC_INIT;
    end else if (spi_ss) begin
      cnt_q <= '0;
      crc_q <= CRC_INIT;
    end else begin
      cnt_q <= cnt_d;
      crc_q <= crc_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '0;
    end else begin
      for (int i = 0; i < FRAME_BYTES; i++)
        if (accept && cnt_base == CW'(i))
          stage_q[i] <= spi_rx_byte;
    end
  end

  // Length checks outrank the CRC check; an empty select is ignored entirely.
  always_comb begin
    eval_good = 1'b0;
    eval_bad  = 1'b0;
    eval_code = CODE_NONE;
    if (eval && cnt_q != '0) begin
      if (cnt_q > CW'(FRAME_BYTES)) begin
        eval_bad  = 1'b1;
        eval_code = CODE_LONG;
      end else if (cnt_q < CW'(FRAME_BYTES)) begin
        eval_bad  = 1'b1;
        eval_code = CODE_SHORT;
      end else if (crc_q != stage_q[FRAME_BYTES-1]) begin
        eval_bad  = 1'b1;
        eval_code = CODE_CRC;
      end else begin
        eval_good = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cmd   <= '0;
      frame_addr  <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= CODE_NONE;
      err_count   <= '0;
    end else begin
      frame_valid <= eval_good;
      frame_err   <= eval_bad;
      if (eval_good) begin
        frame_cmd  <= stage_q[0];
        frame_addr <= stage_q[1];
        frame_data <= stage_q[FRAME_BYTES-2:2];
      end
      if (eval_good || eval_bad)
        err_code <= eval_code;
      if (eval_bad && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

endmodule
